// File: rtl/timer_cascade.sv
// ---------------------------------------------------------------------------
// timer_cascade
//   Multi-stage countdown timer. A prescaler divides the clock into a unit
//   tick, and STAGES cascaded mixed-radix down-counters (e.g. sec/min/hour)
//   count those ticks. Supports one-shot and periodic operation, pause via
//   the enable input, abort, and registered status outputs.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous reset, active-high
//   i_init      load value, stage i at [i*CBIT +: CBIT]
//   i_load      load i_init, clear prescaler, enter RUN
//   i_abort     stop, clear remaining time, enter IDLE
//   i_en        count enable; 0 freezes prescaler and remaining time
//   i_periodic  1: reload i_init on expiry; 0: stop in EXPIRED
//   o_rema      remaining time, same packing as i_init
//   o_done      one-cycle pulse on expiry
//   o_expired   high while in EXPIRED
//   o_busy      high while in RUN
// ---------------------------------------------------------------------------
module timer_cascade #(
  parameter int STAGES   = 3,
  parameter int CBIT     = 6,
  parameter int MOD      = 60,
  parameter int PRESCALE = 100000000,
  parameter int PBIT     = 27
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [STAGES*CBIT-1:0]   i_init,
  input  logic                     i_load,
  input  logic                     i_abort,
  input  logic                     i_en,
  input  logic                     i_periodic,
  output logic [STAGES*CBIT-1:0]   o_rema,
  output logic                     o_done,
  output logic                     o_expired,
  output logic                     o_busy
);

  localparam int W = STAGES * CBIT;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_EXPIRED = 2'd2;

  localparam logic [CBIT-1:0] STAGE_RELOAD = CBIT'(MOD - 1);
  localparam logic [CBIT-1:0] STAGE_ONE    = CBIT'(1);
  localparam logic [PBIT-1:0] PCNT_LAST    = PBIT'(PRESCALE - 1);
  localparam logic [PBIT-1:0] PCNT_ONE     = PBIT'(1);

  logic [1:0]      r_state;
  logic [W-1:0]    r_rema;
  logic [PBIT-1:0] r_pcnt;
  logic            r_done;

  logic [W-1:0]    w_nxt;
  logic            w_borrow;
  logic            w_tick;
  logic            w_expire;

  // Mixed-radix decrement of the remaining time. The borrow ripples from
  // stage 0 upward: a zero stage wraps to MOD-1 and passes the borrow on,
  // the first nonzero stage absorbs it. The top stage has no radix and
  // simply decrements. An all-zero value stays at zero so that a zero load
  // expires on its first tick.
  always_comb begin
    w_nxt    = r_rema;
    w_borrow = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      if (w_borrow) begin
        if (i == STAGES - 1) begin
          w_nxt[i*CBIT +: CBIT] = r_rema[i*CBIT +: CBIT] - STAGE_ONE;
          w_borrow              = 1'b0;
        end else if (r_rema[i*CBIT +: CBIT] != '0) begin
          w_nxt[i*CBIT +: CBIT] = r_rema[i*CBIT +: CBIT] - STAGE_ONE;
          w_borrow              = 1'b0;
        end else begin
          w_nxt[i*CBIT +: CBIT] = STAGE_RELOAD;
        end
      end
    end
    if (r_rema == '0) begin
      w_nxt = '0;
    end
  end

  // A tick only exists while running and enabled; pausing freezes the
  // prescaler, so an expiry can never slip through during a pause.
  assign w_tick   = (r_state == S_RUN) && i_en && (r_pcnt == PCNT_LAST);
  assign w_expire = w_tick && (w_nxt == '0);

  // Main sequential block. Priority is reset > abort > load > tick; a load
  // arriving on a tick cycle discards that tick and restarts the prescaler.
  // done is registered so it lines up with the rema update of the expiring
  // tick, and abort on that same cycle suppresses it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_rema  <= '0;
      r_pcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_rema  <= '0;
        r_pcnt  <= '0;
      end else if (i_load) begin
        r_state <= S_RUN;
        r_rema  <= i_init;
        r_pcnt  <= '0;
      end else if ((r_state == S_RUN) && i_en) begin
        if (w_tick) begin
          r_pcnt <= '0;
          if (w_expire) begin
            r_done <= 1'b1;
            if (i_periodic) begin
              r_rema <= i_init;
            end else begin
              r_rema  <= '0;
              r_state <= S_EXPIRED;
            end
          end else begin
            r_rema <= w_nxt;
          end
        end else begin
          r_pcnt <= r_pcnt + PCNT_ONE;
        end
      end
    end
  end

  assign o_rema    = r_rema;
  assign o_done    = r_done;
  assign o_expired = (r_state == S_EXPIRED);
  assign o_busy    = (r_state == S_RUN);

endmodule

// File: tb/tb_timer_cascade.sv
// ---------------------------------------------------------------------------
// tb_timer_cascade
//   Directed bench for timer_cascade with STAGES=2, CBIT=4, MOD=10,
//   PRESCALE=4. Expected done pulses are queued by the stimulus thread and
//   consumed by a monitor that fires on every done pulse; level checks on
//   rema/expired/busy are made inline at chosen cycles.
// ---------------------------------------------------------------------------
module tb_timer_cascade;

  localparam int STAGES   = 2;
  localparam int CBIT     = 4;
  localparam int MOD      = 10;
  localparam int PRESCALE = 4;
  localparam int PBIT     = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] init;
  logic       load;
  logic       abort;
  logic       en;
  logic       periodic;
  logic [7:0] rema;
  logic       done;
  logic       expired;
  logic       busy;

  int cyc = 0;
  int base = 0;
  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    int         cycle;
    logic [7:0] rema;
    logic       expired;
    logic       busy;
  } doneExpT;

  doneExpT sbQueue[$];
  doneExpT monEntry;

  timer_cascade #(
    .STAGES(STAGES), .CBIT(CBIT), .MOD(MOD), .PRESCALE(PRESCALE), .PBIT(PBIT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_init(init), .i_load(load), .i_abort(abort),
    .i_en(en), .i_periodic(periodic), .o_rema(rema), .o_done(done),
    .o_expired(expired), .o_busy(busy)
  );

  // Free-running clock and an absolute cycle counter that steps on each
  // rising edge; everything in the bench samples on the falling edge.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual,
               expected, cyc - base);
    end
  endtask

  // Drive a load in the current cycle (which becomes relative cycle 0) and
  // release it on the next falling edge.
  task automatic applyStimulus(input logic [7:0] value, input logic per);
    init     = value;
    periodic = per;
    load     = 1'b1;
    base     = cyc;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic gotoCycle(input int rel);
    while ((cyc - base) < rel) @(negedge clk);
  endtask

  task automatic expectDone(input int rel, input logic [7:0] r, input logic ex,
                            input logic bz);
    doneExpT e;
    e.cycle   = base + rel;
    e.rema    = r;
    e.expired = ex;
    e.busy    = bz;
    sbQueue.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation in
  // cycle, remaining time and status outputs.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbQueue.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_done: done=1 at abs cycle %0d, expected no pulse", cyc);
      end else begin
        monEntry = sbQueue.pop_front();
        checkOutput("done_cycle", cyc, monEntry.cycle);
        checkOutput("done_rema", rema, monEntry.rema);
        checkOutput("done_expired", expired, monEntry.expired);
        checkOutput("done_busy", busy, monEntry.busy);
      end
    end
  end

  // Runaway guard in case the design stalls the stimulus thread.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    load     = 1'b1;
    en       = 1'b1;
    abort    = 1'b0;
    periodic = 1'b0;
    init     = 8'h12;
    repeat (3) @(negedge clk);

    // Reset overrides an active load.
    checkOutput("rst_rema", rema, 8'h00);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_expired", expired, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    rst  = 1'b0;
    load = 1'b0;
    @(negedge clk);

    // One-shot 12 ticks.
    applyStimulus(8'h12, 1'b0);
    expectDone(49, 8'h00, 1'b1, 1'b0);
    gotoCycle(5);
    checkOutput("os_rema_c5", rema, 8'h11);
    checkOutput("os_busy_c5", busy, 1'b1);
    gotoCycle(13);
    checkOutput("os_rema_c13", rema, 8'h09);
    gotoCycle(48);
    checkOutput("os_nodone_c48", done, 1'b0);
    gotoCycle(50);
    checkOutput("os_done_c50", done, 1'b0);
    checkOutput("os_expired_c50", expired, 1'b1);
    checkOutput("os_rema_c50", rema, 8'h00);
    gotoCycle(55);
    checkOutput("os_expired_c55", expired, 1'b1);
    checkOutput("os_busy_c55", busy, 1'b0);

    // Pause for cycles 20..29 delays expiry by ten cycles.
    applyStimulus(8'h12, 1'b0);
    expectDone(59, 8'h00, 1'b1, 1'b0);
    gotoCycle(20);
    checkOutput("pause_rema_c20", rema, 8'h08);
    en = 1'b0;
    gotoCycle(29);
    checkOutput("pause_rema_c29", rema, 8'h08);
    checkOutput("pause_busy_c29", busy, 1'b1);
    gotoCycle(30);
    en = 1'b1;
    gotoCycle(31);
    checkOutput("pause_rema_c31", rema, 8'h07);
    gotoCycle(62);
    checkOutput("pause_expired_c62", expired, 1'b1);

    // Reset in the middle of a run.
    applyStimulus(8'h12, 1'b0);
    gotoCycle(6);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_rema", rema, 8'h00);
    checkOutput("midrst_expired", expired, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Periodic with a three-tick period, then abort.
    applyStimulus(8'h03, 1'b1);
    expectDone(13, 8'h03, 1'b0, 1'b1);
    expectDone(25, 8'h03, 1'b0, 1'b1);
    expectDone(37, 8'h03, 1'b0, 1'b1);
    gotoCycle(14);
    checkOutput("per_rema_c14", rema, 8'h03);
    gotoCycle(38);
    checkOutput("per_busy_c38", busy, 1'b1);
    gotoCycle(40);
    abort = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    periodic = 1'b0;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_rema", rema, 8'h00);
    checkOutput("abort_expired", expired, 1'b0);

    // Zero load expires after one tick; reload from EXPIRED.
    applyStimulus(8'h00, 1'b0);
    expectDone(5, 8'h00, 1'b1, 1'b0);
    gotoCycle(8);
    checkOutput("zero_expired_c8", expired, 1'b1);
    applyStimulus(8'h02, 1'b0);
    expectDone(9, 8'h00, 1'b1, 1'b0);
    checkOutput("reload_expired_c9", expired, 1'b0);
    checkOutput("reload_busy_c9", busy, 1'b1);
    gotoCycle(12);

    // Load on a tick cycle: no decrement and the prescaler restarts.
    applyStimulus(8'h05, 1'b0);
    gotoCycle(4);
    applyStimulus(8'h07, 1'b0);
    checkOutput("loadtick_rema_c1", rema, 8'h07);
    gotoCycle(4);
    checkOutput("loadtick_rema_c4", rema, 8'h07);
    gotoCycle(5);
    checkOutput("loadtick_rema_c5", rema, 8'h06);

    // Abort on the expiring tick: no done pulse.
    applyStimulus(8'h01, 1'b0);
    gotoCycle(4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortexp_done", done, 1'b0);
    checkOutput("abortexp_rema", rema, 8'h00);
    checkOutput("abortexp_busy", busy, 1'b0);
    checkOutput("abortexp_expired", expired, 1'b0);
    gotoCycle(10);
    checkOutput("abortexp_busy_c10", busy, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("sb_empty", sbQueue.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
